// File: rtl/svga_pixel_fifo.sv
// svga_pixel_fifo: elastic 12-bit RGB pixel buffer re-timed onto the SVGA
// raster. The producer writes through valid/ready with an sof marker. The
// raster side pops on de, aligned by frame_start.
// Optional build macro SVGA_PIXFIFO_UFLOW_MARK_EN: pixels blanked because of
// underflow or a short producer frame show magenta for one cycle, not black.
module svga_pixel_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [11:0]   s_data,
  input  logic          s_sof,
  input  logic          de,
  input  logic          frame_start,
  input  logic          err_clr,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue,
  output logic          uflow,
  output logic          desync,
  output logic [AW:0]   level
);

  typedef enum logic [1:0] {SYNC, ARMED, RUN} state_e;

`ifdef SVGA_PIXFIFO_UFLOW_MARK_EN
  localparam logic [11:0] MARK_RGB = 12'hF0F;
`else
  localparam logic [11:0] MARK_RGB = 12'h000;
`endif

  logic [12:0]  mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q, level_w;
  state_e       state_q, state_d;
  logic [11:0]  rgb_q, rgb_d;
  logic         uflow_q, desync_q;
  logic         set_uf, set_ds, mark;
  logic         push, pop, empty, full, head_sof;
  logic [12:0]  head;

  // Extra pointer bit distinguishes full from empty; the occupancy is the difference.
  assign level_w  = wr_ptr_q - rd_ptr_q;
  assign empty    = (level_w == '0);
  assign full     = (level_w == (AW+1)'(DEPTH));
  // No push-through when full: ready depends only on stored occupancy.
  assign s_ready  = !full;
  assign push     = s_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_sof = !empty && head[12];

  // Storage array; pointers carry the reset, so the data needs none.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_sof, s_data};
  end

  // Raster alignment decision: what to pop, what to show, which errors to raise.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    rgb_d   = 12'h000;
    set_uf  = 1'b0;
    set_ds  = 1'b0;
    mark    = 1'b0;
    case (state_q)
      SYNC: begin
        // Drop stale pixels until a frame head lines up with frame_start.
        if (frame_start && head_sof) state_d = ARMED;
        else if (!empty && !head_sof) pop = 1'b1;
      end
      ARMED: begin
        if (!frame_start && de && !empty) begin
          pop     = 1'b1;
          rgb_d   = head[11:0];
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_start) begin
          // A new frame start outranks de. Any leftover non-sof data means the producer frame was too long.
          if (empty)         state_d = SYNC;
          else if (head_sof) state_d = ARMED;
          else begin
            set_ds  = 1'b1;
            state_d = SYNC;
          end
        end else if (de) begin
          if (empty) begin
            set_uf  = 1'b1;
            mark    = 1'b1;
            state_d = SYNC;
          end else if (head_sof) begin
            // The producer frame was too short. Keep the sof pixel for the next frame.
            set_ds  = 1'b1;
            mark    = 1'b1;
            state_d = SYNC;
          end else begin
            pop   = 1'b1;
            rgb_d = head[11:0];
          end
        end
      end
      default: state_d = SYNC;
    endcase
    if (mark) rgb_d = MARK_RGB;
  end

  // Pointers, state, registered DAC pixel and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= SYNC;
      rgb_q    <= 12'h000;
      uflow_q  <= 1'b0;
      desync_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q  <= state_d;
      rgb_q    <= rgb_d;
      uflow_q  <= set_uf | (uflow_q & ~err_clr);
      desync_q <= set_ds | (desync_q & ~err_clr);
    end
  end

  assign red    = rgb_q[11:8];
  assign green  = rgb_q[7:4];
  assign blue   = rgb_q[3:0];
  assign uflow  = uflow_q;
  assign desync = desync_q;
  assign level  = level_w;

endmodule

// File: tb/tb_svga_pixel_fifo.sv
// Scoreboard bench for svga_pixel_fifo. A queue-based reference model predicts
// each cycle's outputs. A monitor compares them just after every rising edge.
`timescale 1ns/1ps
module tb_svga_pixel_fifo;
  localparam int DEPTH = 16;
  localparam int FL    = 6;
`ifdef SVGA_PIXFIFO_UFLOW_MARK_EN
  localparam logic [11:0] MARK = 12'hF0F;
`else
  localparam logic [11:0] MARK = 12'h000;
`endif

  logic clk = 1'b0;
  logic rst_n, s_valid, s_ready, s_sof, de, frame_start, err_clr;
  logic [11:0] s_data;
  logic [3:0] red, green, blue;
  logic uflow, desync;
  logic [4:0] level;

  svga_pixel_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .de(de), .frame_start(frame_start),
    .err_clr(err_clr), .red(red), .green(green), .blue(blue),
    .uflow(uflow), .desync(desync), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    bit uf;
    bit ds;
    int lvl;
    bit rdy;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain queue of {sof, rgb} plus the raster phase.
  localparam int M_SYNC = 0, M_ARMED = 1, M_RUN = 2;
  int mode = M_SYNC;
  bit m_uf = 0, m_ds = 0;
  logic [12:0] mq[$];

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: DUT outputs are registered, so read them just after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("rgb",     int'({red, green, blue}), int'(e.rgb));
      chk("uflow",   int'(uflow),   int'(e.uf));
      chk("desync",  int'(desync),  int'(e.ds));
      chk("level",   int'(level),   e.lvl);
      chk("s_ready", int'(s_ready), int'(e.rdy));
    end
  end

  // Predict the outcome of the coming edge from the inputs that are currently driven.
  task automatic model_step(output bit acc);
    exp_t e;
    bit empty, hs, popd, su, sds, mark;
    logic [11:0] px;
    acc = 0; popd = 0; su = 0; sds = 0; mark = 0; px = 12'h000;
    if (!rst_n) begin
      mq.delete();
      mode = M_SYNC;
      m_uf = 0;
      m_ds = 0;
    end else begin
      empty = (mq.size() == 0);
      hs    = !empty && mq[0][12];
      acc   = s_valid && (mq.size() < DEPTH);
      if (mode == M_SYNC) begin
        if (frame_start && hs) mode = M_ARMED;
        else if (!empty && !hs) popd = 1;
      end else if (mode == M_ARMED) begin
        if (de && !frame_start && !empty) begin
          popd = 1; px = mq[0][11:0]; mode = M_RUN;
        end
      end else begin
        if (frame_start) begin
          if (!empty && !hs) sds = 1;
          mode = (!empty && hs) ? M_ARMED : M_SYNC;
        end else if (de) begin
          if (empty)   begin su = 1;  mark = 1; mode = M_SYNC; end
          else if (hs) begin sds = 1; mark = 1; mode = M_SYNC; end
          else begin popd = 1; px = mq[0][11:0]; end
        end
      end
      if (popd) mq.delete(0);
      if (acc) mq.push_back({s_sof, s_data});
      m_uf = su  || (m_uf && !err_clr);
      m_ds = sds || (m_ds && !err_clr);
    end
    e.rgb = mark ? MARK : px;
    e.uf  = m_uf;
    e.ds  = m_ds;
    e.lvl = mq.size();
    e.rdy = (mq.size() < DEPTH);
    expq.push_back(e);
  endtask

  // Drive inputs for one cycle (called at a falling edge).
  task automatic cycle(input bit sv, input logic [11:0] sd, input bit ss,
                       input bit d, input bit fs, input bit ec, output bit acc);
    s_valid = sv; s_data = sd; s_sof = ss; de = d; frame_start = fs; err_clr = ec;
    model_step(acc);
    @(negedge clk);
  endtask

  task automatic dc(input bit sv, input logic [11:0] sd, input bit ss,
                    input bit d, input bit fs, input bit ec);
    bit a;
    cycle(sv, sd, ss, d, fs, ec, a);
  endtask

  task automatic idle(input int n);
    repeat (n) dc(0, 12'h000, 0, 0, 0, 0);
  endtask

  // Random producer backlog and a raster cycle that draws from it.
  logic [12:0] pend[$];
  task automatic rcycle(input bit d, input bit fs);
    bit a, v;
    logic [12:0] w;
    v = (pend.size() > 0) && ($urandom_range(0, 3) != 0);
    w = v ? pend[0] : 13'h0;
    cycle(v, w[11:0], w[12], d, fs, ($urandom_range(0, 15) == 0), a);
    if (a) pend.delete(0);
  endtask

  initial begin
    rst_n = 0; s_valid = 0; s_data = 0; s_sof = 0; de = 0; frame_start = 0; err_clr = 0;
    @(negedge clk);
    idle(2);                       // cycles inside reset: expect reset values
    rst_n = 1;

    // Basic frame: first pixel B00 with sof, then three pixels, 4 de cycles.
    dc(1, 12'hB00, 1, 0, 0, 0);
    dc(1, 12'h123, 0, 0, 0, 0);
    dc(1, 12'h456, 0, 0, 0, 0);
    dc(1, 12'h789, 0, 0, 0, 0);
    idle(1);
    dc(0, 0, 0, 0, 1, 0);
    repeat (4) dc(0, 0, 0, 1, 0, 0);
    idle(2);

    // Stale pixels are dropped in SYNC. The sof pixel then starts the frame, and the next de underflows.
    dc(1, 12'h111, 0, 0, 0, 0);
    dc(1, 12'h222, 0, 0, 0, 0);
    dc(1, 12'h333, 0, 0, 0, 0);
    dc(1, 12'hA5C, 1, 0, 0, 0);
    idle(3);
    dc(0, 0, 0, 0, 1, 0);
    dc(0, 0, 0, 1, 0, 0);
    dc(0, 0, 0, 1, 0, 0);          // empty in RUN: underflow
    idle(2);
    dc(0, 0, 0, 0, 0, 1);          // clear
    idle(1);

    // Long producer frame: 5 pixels for a 4-pixel raster.
    for (int i = 0; i < 5; i++) dc(1, 12'(12'h300 + i), (i == 0), 0, 0, 0);
    dc(0, 0, 0, 0, 1, 0);
    repeat (4) dc(0, 0, 0, 1, 0, 0);
    dc(0, 0, 0, 0, 1, 0);          // leftover non-sof: desync
    idle(1);
    for (int i = 0; i < 4; i++) dc(1, 12'(12'h7A0 + i), (i == 0), 0, 0, 0);
    dc(0, 0, 0, 0, 1, 1);
    repeat (4) dc(0, 0, 0, 1, 0, 0);
    idle(2);

    // Fill to full with valid held high, then pop while a push is refused.
    for (int i = 0; i < 18; i++) dc(1, 12'(i * 7 + 1), (i == 0), 0, 0, 0);
    dc(1, 12'hEEE, 0, 0, 1, 0);
    dc(1, 12'hEEE, 0, 1, 0, 0);
    idle(1);
    repeat (15) dc(0, 0, 0, 1, 0, 0);
    dc(0, 0, 0, 0, 1, 0);          // empty at frame_start: quiet resync
    idle(1);

    // frame_start together with de while an sof sits at the head.
    dc(1, 12'hC01, 1, 0, 0, 0);
    dc(1, 12'hC02, 0, 0, 0, 0);
    dc(1, 12'hD01, 1, 0, 0, 0);
    dc(1, 12'hD02, 0, 0, 0, 0);
    dc(0, 0, 0, 0, 1, 0);
    dc(0, 0, 0, 1, 0, 0);
    dc(0, 0, 0, 1, 0, 0);
    dc(0, 0, 0, 1, 1, 0);          // no pop, black, re-armed
    dc(0, 0, 0, 1, 0, 0);
    dc(0, 0, 0, 1, 0, 0);
    idle(2);

    // Randomised frames with occasional length mismatches, error clears and a mid-frame reset.
    for (int f = 0; f < 40; f++) begin
      int pl, r;
      pl = FL;
      r = $urandom_range(0, 7);
      if (r == 0) pl = FL - 1;
      else if (r == 1) pl = FL + 1;
      for (int i = 0; i < pl; i++) pend.push_back({(i == 0), 12'($urandom)});
      if (f == 20) begin
        rcycle(1, 0);
        rst_n = 0;
        rcycle(0, 0);
        rcycle(0, 0);
        rst_n = 1;
      end
      rcycle(0, 1);
      repeat ($urandom_range(1, 3)) rcycle(0, 0);
      for (int p = 0; p < FL; p++) begin
        repeat ($urandom_range(0, 2)) rcycle(0, 0);
        rcycle(1, 0);
      end
      repeat ($urandom_range(0, 3)) rcycle(0, 0);
    end

    idle(2);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/svga_pixel_fifo.md
# svga_pixel_fifo

Pixel-stream elastic buffer sitting directly upstream of the SVGA 800x600 output stage. It accepts 12-bit RGB pixels from a producer over a valid/ready handshake with a start-of-frame marker, then re-times them onto the display raster using the timing generator's display-enable and frame-start strobes. It drives the 4/4/4 DAC pins with registered output, blanks outside the active area, and detects underflow and frame desynchronisation.

## Interface
- DEPTH, 16: FIFO entries; power of two, at least 4.
- AW, log2(DEPTH): address width; derived, do not override.

- clk  in  1  pixel clock (40 MHz); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  producer pixel valid.
- s_ready  out  1  FIFO can accept; equals !full.
- s_data  in  12  pixel {r[3:0], g[3:0], b[3:0]}.
- s_sof  in  1  qualifies s_data as the first pixel of a frame.
- de  in  1  display enable from timing generator (active pixel this cycle).
- frame_start  in  1  one-cycle strobe per frame, before first active line.
- err_clr  in  1  clears sticky error flags.
- red, green, blue  out  4 each  registered DAC outputs.
- uflow  out  1  sticky: active pixel requested with FIFO empty.
- desync  out  1  sticky: producer frame length mismatched raster.
- level  out  AW+1  current FIFO occupancy.

## Operation
- Storage: DEPTH x 13 bits {sof, rgb}. Push when s_valid && s_ready. No push-through-when-full: s_ready is 0 at full even if a pop occurs that cycle. Push and pop in the same cycle leave level unchanged.
- Head entry is the oldest entry; head_sof is its sof bit.
- Three states:
  - SYNC (reset state): pop and discard the head whenever it is non-empty and !head_sof. On frame_start with head_sof: go to ARMED. frame_start without head_sof: stay.
  - ARMED: on de, pop head, drive its RGB, go to RUN.
  - RUN: on de with non-empty FIFO and !head_sof, pop and drive. On de with empty FIFO: drive black, set uflow, go to SYNC. On de with head_sof (producer frame short): drive black, set desync, go to SYNC without popping. On frame_start: head_sof goes to ARMED; empty FIFO goes to SYNC with no error; non-empty FIFO without head_sof (producer frame long) sets desync and goes to SYNC.
- Priority: frame_start beats de in the same cycle; de is ignored and output is black.
- err_clr clears uflow and desync. A simultaneous set wins over the clear.
- Outputs are black whenever no pixel is popped for display.

## Timing
- Reset values: red/green/blue 0, uflow 0, desync 0, level 0, state SYNC, s_ready 1. Pushes are ignored while rst_n is low.
- Reset mid-frame: contents are flushed. The block resyncs on the next frame_start that sees an sof head.
- Display latency: RGB appears 1 clk after the de cycle that popped it. The timing generator delays de by one cycle to align, matching its registered sync outputs.
- Write-to-read latency: a pushed entry is visible at the head the next cycle. An entry written into an empty FIFO can be popped 1 clk after its push.
- level updates 1 clk after the push or pop.
- Sticky flags assert 1 clk after the triggering cycle.

## Configuration
- SVGA_PIXFIFO_UFLOW_MARK_EN:
  - Defined: pixels blanked because of underflow or short-frame desync drive magenta (red=4'hF, green=0, blue=4'hF) for that one cycle. They then go black for the remainder of the frame.
  - Undefined: those pixels drive black, like all other blanking.

## Test plan
- Reset, then push 4 pixels (first with sof, value 12'hB00), frame_start, then 4 de cycles -> red=4'hB on the first output cycle, pixels out in order, uflow=0, desync=0, level returns to 0.
- Push 3 non-sof pixels then an sof pixel while in SYNC -> 3 pixels discarded, level=1. frame_start -> ARMED. The first de outputs the sof pixel.
- In RUN, de with FIFO empty -> output black (magenta with macro), uflow=1, state SYNC. err_clr -> uflow=0.
- Producer pushes 5 pixels for a 4-pixel raster, then frame_start -> desync=1, the extra pixel is discarded, and sync is reached on the next sof.
- Fill to DEPTH=16 with s_valid held high -> s_ready=0, level=16. A push attempt in the same cycle as a pop is rejected and level=15 afterwards.
- frame_start and de in the same cycle in RUN with sof head -> no pop, output black, state ARMED.
